// File: rtl/apb4_ram_if.sv
// APB4 bus bundle between a requester and the apb4_ram slave.
// Parameters must match the attached apb4_ram instance.
interface apb4_ram_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb4_ram.sv
// APB4 slave RAM with byte strobes, programmable wait states,
// address/alignment error responses and a saturating error counter.
module apb4_ram #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic       pclk,
   input  logic       preset,
   apb4_ram_if.slave  bus,
   output logic [7:0] err_count
);
   localparam int NB  = DATA_W / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH * NB);
   localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(NB - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [IW-1:0]       idx;
   logic                wr_l;
   logic                err_l;
   logic [DATA_W-1:0]   wdata_l;
   logic [NB-1:0]       strb_l;
   logic [DATA_W-1:0]   rdata;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                setup;
   logic                dec_err;
   logic [IW-1:0]       dec_idx;

   // Decode is taken from the live bus only at the setup edge, then held.
   assign dec_err = ({1'b0, bus.paddr} >= LIMIT) ||
                    ((bus.paddr & AMASK) != '0);
   assign dec_idx = bus.paddr[LSB +: IW];
   assign setup   = (state == IDLE) && bus.psel && !bus.penable;

   assign bus.pready  = (state == ACCESS) && bus.psel && (cnt == 4'd0);
   assign bus.pslverr = bus.pready && err_l;
   assign bus.prdata  = rdata;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         wr_l      <= 1'b0;
         err_l     <= 1'b0;
         wdata_l   <= '0;
         strb_l    <= '0;
         rdata     <= '0;
         err_count <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (setup) begin
                  state   <= ACCESS;
                  cnt     <= 4'(WAIT_STATES);
                  idx     <= dec_idx;
                  wr_l    <= bus.pwrite;
                  err_l   <= dec_err;
                  wdata_l <= bus.pwdata;
                  strb_l  <= bus.pstrb;
                  if (!bus.pwrite)
                     rdata <= dec_err ? '0 : mem[dec_idx];
               end
            end
            ACCESS: begin
               if (!bus.psel) begin
                  state <= IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= IDLE;
                  if (err_l) begin
                     if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                  end else if (wr_l) begin
                     for (int b = 0; b < NB; b++)
                        if (strb_l[b])
                           mem[idx][8*b +: 8] <= wdata_l[8*b +: 8];
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: doc/apb4_ram.md
APB4_RAM -- requirements
Module: apb4_ram

Interface
REQ-001 SHALL take parameter DATA_W, default 32, data bus width in bits; legal values are 8, 16, 32 or 64.
REQ-002 SHALL take parameter DEPTH, default 64, number of memory words; must be a power of two, at least 2.
REQ-003 SHALL take parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL take parameter WAIT_STATES, default 0, access-phase wait cycles inserted before pready; range 0..15.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 pclk  input  1  clock; all state changes on its rising edge.
REQ-007 preset  input  1  synchronous active-high reset.
REQ-008 psel  input  1  slave select.
REQ-009 penable  input  1  access-phase indicator.
REQ-010 pwrite  input  1  1 = write, 0 = read.
REQ-011 paddr  input  ADDR_W  byte address.
REQ-012 pwdata  input  DATA_W  write data.
REQ-013 pstrb  input  DATA_W/8  byte write strobes; bit i enables byte i.
REQ-014 prdata  output  DATA_W  registered read data.
REQ-015 pready  output  1  transfer-complete indicator.
REQ-016 pslverr  output  1  error response; valid only while pready=1.
REQ-017 err_count  output  8  saturating count of error responses.

Function
REQ-018 SHALL use FSM states IDLE and ACCESS, plus a 4-bit wait counter.
REQ-019 IDLE: psel=1 and penable=0 (setup cycle) -> latch paddr/pwrite/pwdata/pstrb, load counter=WAIT_STATES, go to ACCESS; otherwise stay in IDLE; penable=1 in IDLE is ignored.
REQ-020 ACCESS with counter>0 -> pready=0, decrement counter.
REQ-021 ACCESS with counter=0 -> pready=1 that cycle, complete the transfer at the clock edge, return to IDLE.
REQ-022 pready and pslverr SHALL be combinational from state, counter and latched decode; WAIT_STATES=0 gives pready=1 in the first access cycle.
REQ-023 Word index = paddr >> log2(DATA_W/8).
REQ-024 Error conditions: paddr >= DEPTH*DATA_W/8, or paddr low log2(DATA_W/8) bits nonzero.
REQ-025 Error transfer -> pslverr=1 with pready; no memory change; prdata=0 on an error read.
REQ-026 Valid write -> update only the bytes whose pstrb bit is 1; pstrb=0 -> no change and no error.
REQ-027 Valid read -> prdata loaded at the setup edge from the word at the word index; pstrb is ignored.
REQ-028 prdata SHALL hold its value until the next read completes; writes do not disturb it.
REQ-029 psel=0 during ACCESS (aborted transfer) -> return to IDLE next edge, no write, no err_count change, pready stays 0.
REQ-030 Each completed error response SHALL increment err_count by 1, saturating at 255.
REQ-031 Address, data and strobe changes during ACCESS SHALL be ignored; the latched setup values are used.
REQ-032 Back-to-back transfers SHALL be supported: a setup cycle immediately following completion is accepted.

Reset
REQ-033 preset=1 at a clock edge -> state IDLE, counter 0, prdata 0, pready 0, pslverr 0, err_count 0, all memory words 0.
REQ-034 Reset SHALL take priority over any transfer in progress; a write interrupted by reset does not occur.
REQ-035 No output SHALL be X after the first reset edge.

Verification
REQ-036 DATA_W=32, DEPTH=64, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with pstrb=0xF, then read 0x10 -> pready=1 in the first access cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
REQ-037 WAIT_STATES=2: read 0x10 -> pready low for 2 access cycles and high on the 3rd.
REQ-038 Word 0x10 = 0xDEADBEEF, write 0x11223344 with pstrb=0x5 -> a later read returns 0xDE22BE44.
REQ-039 Access to 0x100 (out of range) and to 0x02 (misaligned) -> pslverr=1, no memory change, error read gives prdata=0, err_count=2.
REQ-040 Drop psel mid-ACCESS (WAIT_STATES=3) during a write to 0x20 -> FSM returns to IDLE, and a later read of 0x20 returns 0.
REQ-041 Assert preset during a write's wait states, then read the same address -> read returns 0 and all outputs are 0 after reset; also drive 256+ error transfers -> err_count holds at 255.
